uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), LSB first; receive-side companion to the uart_tx path.
//  Phase-accumulator (NCO) tick at OVERSAMPLE x baud; 2-FF input synchroniser; 3-sample majority per bit.
//  Delivers each byte as a 1-cycle valid pulse to the core logic; no back-pressure.
// PARAMETERS
//  DELTA       16492674  32-bit NCO increment = BAUD*OVERSAMPLE*2^32/CLK_HZ (115200*8 @ 240 MHz)
//  OVERSAMPLE  8         ticks per bit; fixed at 8 (tick counter 3 bits); sample ticks 3,4,5
// PORTS
//  clk        in   1  system clock, 240 MHz
//  rst_n      in   1  asynchronous reset, active-low
//  rx         in   1  serial line, asynchronous, idle high
//  data       out  8  last received byte; held until next valid
//  valid      out  1  1-cycle pulse: data updated, stop bit good
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0; data not updated
//  parity_err out  1  only with UART_RX_PARITY_EN; 1-cycle pulse with valid when parity wrong
//  busy       out  1  high from start-edge detect until stop bit sampled
// BEHAVIOUR
//  Reset: accum=0, sync FFs=1 (idle, no false start), state=IDLE, data=0x00, valid/frame_err/parity_err/busy=0.
//  NCO: {carry,accum}<=accum+DELTA every clk; tick = carry (1-cycle pulse). Free-running, never cleared.
//  rx_s = rx after 2 FFs; rx_d = rx_s delayed 1 clk; falling edge = rx_d & ~rx_s.
//  tcnt: 3-bit tick counter, cleared on start edge, +1 per tick, wraps 7->0 = bit boundary.
//  Bit value = majority of rx_s at ticks 3,4,5 of the bit.
//  FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
//   IDLE : on falling edge -> START, tcnt=0, busy=1. Edge only; line held low never retriggers.
//   START: at tick 5 evaluate majority; 1 -> IDLE, busy=0 (glitch reject, no pulse); 0 -> continue.
//          at tcnt wrap -> DATA, bit index=0.
//   DATA : at tick 5 shift majority into shreg[7] (right shift, LSB first); at wrap idx++; after idx 7 -> PARITY/STOP.
//   PARITY: at tick 5 latch bit; at wrap -> STOP.
//   STOP : at tick 5 (mid stop bit): majority 1 -> data<=shreg, valid=1 next clk; majority 0 -> frame_err=1;
//          both cases -> IDLE, busy=0 same clk. Early return lets next start edge be caught back-to-back.
//  Latency: valid rises 1 clk after stop-bit tick 5 (~9.6 bit times after start edge).
//  valid and frame_err are mutually exclusive. No overrun state: consumer must take data within 1 frame.
//  After frame_err with line stuck low (break): stays IDLE until line returns high then falls again.
//  Reset mid-frame: abort immediately, no pulse; resumes with fresh edge detect after rst_n release.
//  NCO jitter: +/-1 clk on tick; tolerance of line baud mismatch >= +/-3%.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present, even parity over data[7:0];
//   parity_err pulses together with valid when received bit != ^shreg; data still delivered.
//  Undefined: no PARITY state, no parity_err port, frame = start+8+stop.
// STRUCTURE
//  Package uart_pkg: state enum (IDLE/START/DATA/PARITY/STOP), OVERSAMPLE=8, SAMPLE_T0/T1/T2=3/4/5,
//   default DELTA constant, shared with uart_tx.
//  Sub-module uart_baud_nco (DELTA param; clk, rst_n -> tick); reusable by uart_tx. Majority and FSM inline.
// TESTING (bench drives rx at 115200 baud, 2083.33 clk/bit, from a behavioural model)
//  1 Reset, send 0x55 -> single valid pulse, data=0x55, frame_err=0, busy low after.
//  2 Back-to-back 0xA5,0x3C with 1 stop bit, no idle gap -> two valid pulses, data 0xA5 then 0x3C.
//  3 Low glitch of 600 clk (<3/8 bit) on idle line -> no valid, no frame_err, busy pulse only.
//  4 Send 0xF0 with stop bit forced 0 -> frame_err pulse, valid=0, data keeps previous value.
//  5 Assert rst_n=0 during bit 4 of 0x81, release, send 0x7E -> only valid with data=0x7E.
//  6 (PARITY_EN) send 0x07 with parity bit 0 -> valid + parity_err; with parity 1 -> valid only.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive path (and its uart_tx companion):
//   FSM state encoding, oversampling constants, the default NCO increment and
//   a 3-input majority helper.
//
//   Optional feature macro: UART_RX_PARITY_EN (used by uart_rx; the PARITY
//   state value is always present in the enum so both builds share encoding).
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Ticks per bit; the 3-bit tick counter relies on this being 8.
    localparam int          OVERSAMPLE = 8;

    // Tick indices inside a bit at which rx is sampled for the majority vote.
    localparam logic [2:0]  SAMPLE_T0  = 3'd3;
    localparam logic [2:0]  SAMPLE_T1  = 3'd4;
    localparam logic [2:0]  SAMPLE_T2  = 3'd5;

    // Last tick index of a bit; the tick seen here closes the bit.
    localparam logic [2:0]  TCNT_LAST  = 3'd7;

    // 115200 baud * 8 oversample * 2^32 / 240 MHz.
    localparam logic [31:0] DELTA_DEFAULT = 32'd16492674;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// ----------------------------------------------------------------------------
// uart_baud_nco
//   Free-running 32-bit phase accumulator. The carry out of each addition is
//   registered and presented as a single-cycle tick, giving an average tick
//   rate of CLK_HZ * DELTA / 2^32 with +/-1 clk jitter. Never cleared except by
//   reset, so it can be shared by transmit and receive paths.
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active-low
//   tick   out  1-cycle pulse at OVERSAMPLE x baud
// ----------------------------------------------------------------------------
module uart_baud_nco #(
    parameter logic [31:0] DELTA = uart_pkg::DELTA_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [31:0] r_accum;
    logic        r_tick;
    logic [32:0] w_sum;

    assign w_sum = {1'b0, r_accum} + {1'b0, DELTA};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accum <= 32'd0;
            r_tick  <= 1'b0;
        end else begin
            r_accum <= w_sum[31:0];
            r_tick  <= w_sum[32];
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   UART receiver, 8N1, LSB first (8E1 when UART_RX_PARITY_EN is defined).
//   rx passes through a 2-FF synchroniser; a falling edge on the synchronised
//   line starts a frame. Each bit is decided by a majority of three samples
//   taken at oversample ticks 3, 4 and 5. A received byte is delivered as a
//   1-cycle valid pulse; there is no back-pressure.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : even-parity bit after the data, parity_err port present
//     undefined : frame = start + 8 data + stop, no parity_err port
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous reset, active-low
//   rx          in   serial line, asynchronous, idle high
//   data        out  last good byte, held until the next valid
//   valid       out  1-cycle pulse, data updated, stop bit good
//   frame_err   out  1-cycle pulse, stop bit sampled 0, data not updated
//   parity_err  out  (UART_RX_PARITY_EN) pulses with valid on bad parity
//   busy        out  high from start-edge detect until stop bit sampled
//   dbg_state   out  current FSM state
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [31:0] DELTA = DELTA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [7:0]  data,
    output logic        valid,
    output logic        frame_err,
`ifdef UART_RX_PARITY_EN
    output logic        parity_err,
`endif
    output logic        busy,
    output uart_state_t dbg_state
);

    logic        w_tick;

    // Synchroniser and edge detector; reset to 1 so reset looks like idle.
    logic        r_sync1;
    logic        r_sync2;
    logic        r_rx_d;
    logic        w_fall;

    uart_state_t r_state,  w_state_nxt;
    logic [2:0]  r_tcnt,   w_tcnt_nxt;
    logic [2:0]  r_idx,    w_idx_nxt;
    logic [7:0]  r_shreg,  w_shreg_nxt;
    logic        r_s3,     w_s3_nxt;
    logic        r_s4,     w_s4_nxt;
    logic [7:0]  r_data,   w_data_nxt;
    logic        r_valid,  w_valid_nxt;
    logic        r_ferr,   w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic        r_par,    w_par_nxt;
    logic        r_perr,   w_perr_nxt;
`endif

    logic        w_mid;
    logic        w_wrap;
    logic        w_maj;

    uart_baud_nco #(.DELTA(DELTA)) u_nco (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_fall = r_rx_d & ~r_sync2;

    // Decision point is the third sample tick; the two earlier samples are
    // held in r_s3/r_s4 and combined with the live synchronised value.
    assign w_mid  = w_tick && (r_tcnt == SAMPLE_T2);
    assign w_wrap = w_tick && (r_tcnt == TCNT_LAST);
    assign w_maj  = majority3(r_s3, r_s4, r_sync2);

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = w_tick ? (r_tcnt + 3'd1) : r_tcnt;
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        w_s3_nxt    = r_s3;
        w_s4_nxt    = r_s4;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = 1'b0;
`endif

        if (w_tick && (r_tcnt == SAMPLE_T0)) w_s3_nxt = r_sync2;
        if (w_tick && (r_tcnt == SAMPLE_T1)) w_s4_nxt = r_sync2;

        case (r_state)
            IDLE: begin
                // Edge-triggered only: a line held low cannot start a frame.
                if (w_fall) begin
                    w_state_nxt = START;
                    w_tcnt_nxt  = 3'd0;
                end
            end
            START: begin
                if (w_mid) begin
                    // High at mid start bit: glitch, drop back silently.
                    if (w_maj) w_state_nxt = IDLE;
                end else if (w_wrap) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (w_mid) begin
                    w_shreg_nxt = {w_maj, r_shreg[7:1]};
                end else if (w_wrap) begin
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_mid) begin
                    w_par_nxt = w_maj;
                end else if (w_wrap) begin
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is seen.
                if (w_mid) begin
                    w_state_nxt = IDLE;
                    if (w_maj) begin
                        w_data_nxt  = r_shreg;
                        w_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        w_perr_nxt  = (r_par != (^r_shreg));
`endif
                    end else begin
                        w_ferr_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d  <= 1'b1;
            r_state <= IDLE;
            r_tcnt  <= 3'd0;
            r_idx   <= 3'd0;
            r_shreg <= 8'h00;
            r_s3    <= 1'b1;
            r_s4    <= 1'b1;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_rx_d  <= r_sync2;
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shreg <= w_shreg_nxt;
            r_s3    <= w_s3_nxt;
            r_s4    <= w_s4_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign frame_err  = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule
